// File: rtl/palette_ram_pkg.sv
// Shared definitions for the palette RAM: default geometry and clear-engine state encoding.
package palette_ram_pkg;

  localparam int DEF_DW = 8;
  localparam int DEF_AW = 8;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } clr_state_e;

  function automatic int depth_of(input int aw);
    return 1 << aw;
  endfunction

endpackage

// File: rtl/palette_clear_fsm.sv
// Clear engine: walks every address once, writing the clear value, on reset release or on request.
module palette_clear_fsm
  import palette_ram_pkg::*;
#(
  parameter int AW           = DEF_AW,
  parameter bit CLEAR_ON_RST = 1'b1
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          clr_req,
  output logic          busy,
  output logic          clr_we,
  output logic [AW-1:0] clr_addr
);

  localparam logic [AW-1:0] CNT_LAST = '1;

  clr_state_e    state_reg, state_next;
  logic [AW-1:0] cnt_reg, cnt_next;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= CLEAR_ON_RST ? ST_CLEAR : ST_IDLE;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      ST_IDLE: begin
        if (clr_req) begin
          state_next = ST_CLEAR;
          cnt_next   = '0;
        end
      end
      ST_CLEAR: begin
        // Counter wraps to zero on the final write, ready for the next clear.
        cnt_next = cnt_reg + 1'b1;
        if (cnt_reg == CNT_LAST) begin
          state_next = ST_IDLE;
        end
      end
      default: begin
        state_next = ST_IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  assign busy     = (state_reg == ST_CLEAR);
  assign clr_we   = busy;
  assign clr_addr = cnt_reg;

endmodule

// File: rtl/palette_ram.sv
// Dual-port palette RAM: registered CPU read/write port, registered video read port with valid,
// and a built-in clear engine that owns the write port while busy.
module palette_ram
  import palette_ram_pkg::*;
#(
  parameter int            DW           = DEF_DW,
  parameter int            AW           = DEF_AW,
  parameter bit            BYPASS       = 1'b1,
  parameter bit            CLEAR_ON_RST = 1'b1,
  parameter logic [DW-1:0] CLEAR_VAL    = '0
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [AW-1:0] cpu_a,
  input  logic [DW-1:0] cpu_di,
  input  logic          cpu_r_n,
  input  logic          cpu_w_n,
  output logic [DW-1:0] cpu_do,
  input  logic [AW-1:0] vid_a,
  input  logic          vid_r_n,
  output logic [DW-1:0] vid_do,
  output logic          vid_valid,
  input  logic          clr_req,
  output logic          busy
);

  localparam int DEPTH = depth_of(AW);

  logic [DW-1:0] mem [DEPTH];

  logic          clr_we;
  logic [AW-1:0] clr_addr;
  logic          cpu_we;
  logic          mem_we;
  logic [AW-1:0] mem_wa;
  logic [DW-1:0] mem_wd;
  logic          byp_hit;
  logic [DW-1:0] vid_sel;
  logic [DW-1:0] cpu_do_reg;
  logic [DW-1:0] vid_do_reg;
  logic          vid_valid_reg;

  palette_clear_fsm #(
    .AW           (AW),
    .CLEAR_ON_RST (CLEAR_ON_RST)
  ) u_clear_fsm (
    .clk      (clk),
    .reset_n  (reset_n),
    .clr_req  (clr_req),
    .busy     (busy),
    .clr_we   (clr_we),
    .clr_addr (clr_addr)
  );

  // CPU writes are dropped while the clear engine is running.
  assign cpu_we = !cpu_w_n && !busy;

  always_comb begin
    mem_we = clr_we || cpu_we;
    mem_wa = cpu_a;
    mem_wd = cpu_di;
    if (clr_we) begin
      mem_wa = clr_addr;
      mem_wd = CLEAR_VAL;
    end
  end

  // No reset on the array so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_wa] <= mem_wd;
    end
  end

  generate
    if (BYPASS) begin : g_bypass
      assign byp_hit = cpu_we && (cpu_a == vid_a);
    end else begin : g_no_bypass
      assign byp_hit = 1'b0;
    end
  endgenerate

  always_comb begin
    vid_sel = mem[vid_a];
    if (busy) begin
      vid_sel = CLEAR_VAL;
    end else if (byp_hit) begin
      vid_sel = cpu_di;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cpu_do_reg    <= '0;
      vid_do_reg    <= '0;
      vid_valid_reg <= 1'b0;
    end else begin
      if (!cpu_r_n) begin
        cpu_do_reg <= mem[cpu_a];
      end
      vid_valid_reg <= !vid_r_n;
      if (!vid_r_n) begin
        vid_do_reg <= vid_sel;
      end
    end
  end

  assign cpu_do    = cpu_do_reg;
  assign vid_do    = vid_do_reg;
  assign vid_valid = vid_valid_reg;

endmodule
